// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: opcode encoding, result buffer
// state, and the stored entry layout (result, opcode and capture-time flags).
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_OPW   = 2;

    typedef enum logic [ALU_OPW-1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] res;
        alu_op_t              op;
        logic                 zero;
        logic                 par;
    } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Result flag generator: zero detect and odd parity of a unit result.
// Purely combinational so later flag stages can reuse it.
module alu_flag_gen #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             par
);

    assign zero = (res == '0);
    assign par  = ^res;

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry FIFO behind the logic units / adder. Captures result + opcode,
// stamps zero/parity flags at capture, and presents the head on out_*.
// Outputs come only from registered state, so nothing passes in->out
// combinationally. Optional zero-result pop counter: ALU_ZERO_COUNT_EN.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
`ifdef ALU_ZERO_COUNT_EN
    ,
    parameter int CNTW  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_res,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_par
`ifdef ALU_ZERO_COUNT_EN
    ,
    output logic [CNTW-1:0]  zero_cnt
`endif
);

    buf_state_t state, next_state;
    entry_t     slot [2];
    logic       rd_ptr, wr_ptr;
    logic       push, pop;
    logic       new_zero, new_par;
    entry_t     new_entry;
    entry_t     head;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .res  (in_res),
        .zero (new_zero),
        .par  (new_par)
    );

    assign new_entry = '{res: in_res, op: alu_op_t'(in_op), zero: new_zero, par: new_par};

    // Handshake flags depend on state only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);

    // Occupancy state register; async reset empties the buffer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    // Next-state and transfer decode. FULL never pushes, even on a pop cycle.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            EMPTY: begin
                push = in_valid;
                if (push) next_state = ONE;
            end
            ONE: begin
                push = in_valid;
                pop  = out_ready;
                if (push && !pop)      next_state = FULL;
                else if (!push && pop) next_state = EMPTY;
            end
            FULL: begin
                pop = out_ready;
                if (pop) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    // Slot storage and 1-bit pointers; pointers wrap 1->0 by toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= new_entry;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    // Head slot is forced to zero whenever the buffer is empty.
    assign head      = out_valid ? slot[rd_ptr] : '0;
    assign out_res   = head.res;
    assign out_op    = head.op;
    assign out_zero  = head.zero;
    assign out_par   = head.par;

`ifdef ALU_ZERO_COUNT_EN
    // Saturating count of zero results leaving the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        zero_cnt <= '0;
        else if (pop && head.zero && (zero_cnt != '1)) zero_cnt <= zero_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: queue-based reference model compared every
// negative edge, plus directed literal checks. Define ALU_ZERO_COUNT_EN to
// also build and check the zero counter (with CNTW=2).
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_res = '0;
    logic [1:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_res;
    logic [1:0] out_op;
    logic       out_zero;
    logic       out_par;
`ifdef ALU_ZERO_COUNT_EN
    logic [1:0] zero_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] res;
        logic [1:0] op;
    } item_t;

    item_t q[$];
    int    m_zero_cnt = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(
        .WIDTH(4), .OPW(2)
`ifdef ALU_ZERO_COUNT_EN
        , .CNTW(2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_par   (out_par)
`ifdef ALU_ZERO_COUNT_EN
        , .zero_cnt (zero_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of at most two items.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_zero_cnt = 0;
            end else begin
                bit do_pop, do_push;
                do_pop  = out_ready && q.size() > 0;
                do_push = in_valid && q.size() < 2;
                if (do_pop) begin
                    if (q[0].res == 4'd0 && m_zero_cnt < 3) m_zero_cnt++;
                    void'(q.pop_front());
                end
                if (do_push) q.push_back('{res: in_res, op: in_op});
            end
        end
    end

    // Compare DUT against model every cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("m_in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("m_out_res",  {28'd0, out_res}, {28'd0, q[0].res});
                chk("m_out_op",   {30'd0, out_op},  {30'd0, q[0].op});
                chk("m_out_zero", {31'd0, out_zero}, {31'd0, q[0].res == 4'd0});
                chk("m_out_par",  {31'd0, out_par},  {31'd0, ($countones(q[0].res) % 2) == 1});
            end else begin
                chk("m_empty_outs", {24'd0, out_res, out_op, out_zero, out_par}, 32'd0);
            end
`ifdef ALU_ZERO_COUNT_EN
            chk("m_zero_cnt", {30'd0, zero_cnt}, m_zero_cnt);
`endif
        end
    end

    // Drive one cycle of inputs, let the edge take them, return 2 units after.
    task automatic cyc(input logic v, input logic [3:0] r, input logic [1:0] o, input logic rdy);
        in_valid  = v;
        in_res    = r;
        in_op     = o;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic head_is(input string name, input logic [3:0] r, input logic [1:0] o,
                           input logic z, input logic p);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_res"},   {28'd0, out_res},   {28'd0, r});
        chk({name, "_op"},    {30'd0, out_op},    {30'd0, o});
        chk({name, "_flags"}, {30'd0, out_zero, out_par}, {30'd0, z, p});
    endtask

    task automatic empty_is(input string name);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_ready"}, {31'd0, in_ready},  32'd1);
        chk({name, "_outs"},  {24'd0, out_res, out_op, out_zero, out_par}, 32'd0);
    endtask

    initial begin
        // 1: reset state and single-entry latency
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        empty_is("rst");
        rst = 1'b0;
        cyc(1, 4'b0100, OP_AND, 1);
        head_is("t1", 4'd4, 2'd0, 1'b0, 1'b1);
        cyc(0, 0, 0, 1);
        empty_is("t1_drain");

        // 2: flag generation
        cyc(1, 4'd0, OP_XOR, 0);
        head_is("t2_zero", 4'd0, 2'd2, 1'b1, 1'b0);
        cyc(0, 0, 0, 1);
        cyc(1, 4'b0111, OP_OR, 1);
        head_is("t2_seven", 4'd7, 2'd1, 1'b0, 1'b1);
        cyc(0, 0, 0, 1);
        empty_is("t2_drain");

        // 3: backpressure, 12 held upstream until space
        cyc(1, 4'd4, OP_ADD, 0);
        chk("t3_ready1", {31'd0, in_ready}, 32'd1);
        cyc(1, 4'd9, OP_ADD, 0);
        chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
        cyc(1, 4'd12, OP_ADD, 0);
        head_is("t3_hold", 4'd4, 2'd3, 1'b0, 1'b1);
        cyc(1, 4'd12, OP_ADD, 1);
        head_is("t3_pop4", 4'd9, 2'd3, 1'b0, 1'b0);
        cyc(1, 4'd12, OP_ADD, 1);
        head_is("t3_pop9", 4'd12, 2'd3, 1'b0, 1'b0);
        cyc(0, 0, 0, 1);
        empty_is("t3_drain");

        // 4: push+pop in ONE; FULL with in_valid and out_ready
        cyc(1, 4'd3, OP_AND, 0);
        head_is("t4_head3", 4'd3, 2'd0, 1'b0, 1'b0);
        cyc(1, 4'd5, OP_OR, 1);
        head_is("t4_head5", 4'd5, 2'd1, 1'b0, 1'b0);
        chk("t4_one_ready", {31'd0, in_ready}, 32'd1);
        cyc(1, 4'd6, OP_AND, 0);
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        cyc(1, 4'd8, OP_XOR, 1);
        head_is("t4_nopush", 4'd6, 2'd0, 1'b0, 1'b0);
        chk("t4_one_again", {31'd0, in_ready}, 32'd1);
        cyc(0, 0, 0, 1);
        empty_is("t4_drain");

        // 5: asynchronous reset while FULL
        cyc(1, 4'd1, OP_AND, 0);
        cyc(1, 4'd2, OP_AND, 0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 empty_is("t5_async");
        @(posedge clk);
        #2 rst = 1'b0;
        cyc(1, 4'd10, OP_OR, 0);
        head_is("t5_after", 4'd10, 2'd1, 1'b0, 1'b0);
        cyc(0, 0, 0, 1);
        empty_is("t5_drain");

`ifdef ALU_ZERO_COUNT_EN
        // 6: 5 zero pops and 2 nonzero -> saturates at 3
        cyc(1, 4'd0, OP_AND, 1);
        cyc(1, 4'd0, OP_AND, 1);
        cyc(1, 4'd5, OP_ADD, 1);
        cyc(1, 4'd0, OP_AND, 1);
        cyc(1, 4'd0, OP_XOR, 1);
        cyc(1, 4'd9, OP_OR, 1);
        cyc(1, 4'd0, OP_AND, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t6_zero_cnt", {30'd0, zero_cnt}, 32'd3);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
